// File: rtl/snake_tick_scheduler.sv
// Rate-controlled MOVE_REQ/MOVE_ACK step scheduler for the snake datapath.
// Optional macro SNAKE_SPEEDUP_EN: step period shortens with the score level.
//
// state    | meaning
// IDLE     | not playing, counter cleared
// RUN      | counting down to the next step
// WAIT_ACK | MOVE_REQ high, counter keeps running
// PAUSE    | counter frozen, PAUSED high
module snake_tick_scheduler #(
    parameter int BASE_PERIOD = 5000000,
    parameter int STEP_DEC    = 250000,
    parameter int MIN_PERIOD  = 1000000,
    parameter int LEVEL_SHIFT = 2,
    parameter int CNT_W       = 24
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] MSM_State,
    input  logic       PAUSE_KEY,
    input  logic [7:0] SCORE,
    input  logic       MOVE_ACK,
    output logic       MOVE_REQ,
    output logic       PAUSED,
    output logic [3:0] LEVEL,
    output logic       OVERRUN
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_ACK, S_PAUSE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overrun_q, overrun_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] period_w, reload_w;
    logic             play_w, cnt_zero_w;

`ifdef SNAKE_SPEEDUP_EN
    logic [3:0]  level_q;
    logic [7:0]  score_shift_w;
    logic [31:0] dec_w;

    assign score_shift_w = SCORE >> LEVEL_SHIFT;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) level_q <= 4'd0;
        else        level_q <= (score_shift_w > 8'd15) ? 4'd15 : score_shift_w[3:0];
    end

    // Clamp before subtracting so deep levels never wrap below the floor.
    assign dec_w    = 32'(level_q) * 32'(STEP_DEC);
    assign period_w = (dec_w > 32'(BASE_PERIOD - MIN_PERIOD)) ? CNT_W'(MIN_PERIOD)
                                                              : CNT_W'(32'(BASE_PERIOD) - dec_w);
    assign LEVEL    = level_q;
`else
    logic unused_cfg;

    assign unused_cfg = ^{SCORE, 32'(STEP_DEC), 32'(MIN_PERIOD), 32'(LEVEL_SHIFT)};
    assign period_w   = CNT_W'(BASE_PERIOD);
    assign LEVEL      = 4'd0;
`endif

    assign reload_w   = period_w - CNT_W'(1);
    assign play_w     = (MSM_State == 2'b01);
    assign cnt_zero_w = (cnt_q == '0);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
            pend_q    <= pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        pend_d    = pend_q;
        if (state_q != S_IDLE && !play_w) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (play_w) begin
                        cnt_d     = reload_w;
                        overrun_d = 1'b0;
                        state_d   = S_RUN;
                    end
                end
                S_RUN: begin
                    // A pause key landing on the tick defers until the request completes.
                    if (cnt_zero_w) begin
                        cnt_d   = reload_w;
                        pend_d  = PAUSE_KEY;
                        state_d = S_WAIT_ACK;
                    end else if (PAUSE_KEY) begin
                        state_d = S_PAUSE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_WAIT_ACK: begin
                    cnt_d = cnt_zero_w ? reload_w : cnt_q - CNT_W'(1);
                    if (MOVE_ACK) begin
                        state_d = (pend_q || PAUSE_KEY) ? S_PAUSE : S_RUN;
                        pend_d  = 1'b0;
                    end else begin
                        if (cnt_zero_w) overrun_d = 1'b1;
                        if (PAUSE_KEY)  pend_d    = 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (PAUSE_KEY) state_d = S_RUN;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        MOVE_REQ = (state_q == S_WAIT_ACK);
        PAUSED   = (state_q == S_PAUSE);
        OVERRUN  = overrun_q;
    end

endmodule

// File: tb/tb_snake_tick_scheduler.sv
// Self-checking bench for snake_tick_scheduler: directed scenarios plus a random
// phase, all compared against a cycle-level behavioural model of the step rules.
module tb_snake_tick_scheduler;

    localparam int BASE = 20;
    localparam int STEP = 4;
    localparam int MINP = 8;
`ifdef SNAKE_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [1:0] MSM_State = 2'b00;
    logic       PAUSE_KEY = 1'b0;
    logic [7:0] SCORE = 8'd0;
    logic       MOVE_ACK = 1'b0;
    logic       MOVE_REQ, PAUSED, OVERRUN;
    logic [3:0] LEVEL;

    snake_tick_scheduler #(
        .BASE_PERIOD(BASE), .STEP_DEC(STEP), .MIN_PERIOD(MINP),
        .LEVEL_SHIFT(2), .CNT_W(24)
    ) dut (
        .CLK(CLK), .RESET(RESET), .MSM_State(MSM_State), .PAUSE_KEY(PAUSE_KEY),
        .SCORE(SCORE), .MOVE_ACK(MOVE_ACK), .MOVE_REQ(MOVE_REQ), .PAUSED(PAUSED),
        .LEVEL(LEVEL), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: m_left = clock edges still needed before the next request rises.
    bit m_active, m_req, m_paused, m_pend, m_ovr;
    int m_left, m_level;

    bit auto_ack = 1'b0;
    bit prev_req = 1'b0, prev_ovr = 1'b0;
    bit rise_now, ovr_rise_now;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int period_of(input int lvl);
        if (lvl * STEP > BASE - MINP) return MINP;
        return BASE - lvl * STEP;
    endfunction

    task automatic model_reset();
        m_active = 0; m_req = 0; m_paused = 0; m_pend = 0; m_ovr = 0;
        m_left = 0; m_level = 0;
    endtask

    task automatic model_step();
        int p, new_level, sh;
        bit expire;
        sh        = int'(SCORE) / 4;
        new_level = SPEEDUP ? ((sh > 15) ? 15 : sh) : 0;
        p         = period_of(m_level);
        if (!m_active) begin
            if (MSM_State == 2'b01) begin m_active = 1; m_left = p; m_ovr = 0; end
        end else if (MSM_State != 2'b01) begin
            m_active = 0; m_req = 0; m_paused = 0; m_pend = 0;
        end else if (m_paused) begin
            if (PAUSE_KEY) m_paused = 0;
        end else if (!m_req) begin
            if (m_left == 1) begin m_req = 1; m_left = p; m_pend = PAUSE_KEY; end
            else if (PAUSE_KEY) m_paused = 1;
            else m_left--;
        end else begin
            expire = (m_left == 1);
            m_left = expire ? p : m_left - 1;
            if (MOVE_ACK) begin
                m_req = 0; m_paused = m_pend | PAUSE_KEY; m_pend = 0;
            end else begin
                if (expire)    m_ovr  = 1;
                if (PAUSE_KEY) m_pend = 1;
            end
        end
        m_level = new_level;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        cyc++;
        #1;
        chk("move_req", 32'(MOVE_REQ), 32'(m_req));
        chk("paused",   32'(PAUSED),   32'(m_paused));
        chk("overrun",  32'(OVERRUN),  32'(m_ovr));
        chk("level",    32'(LEVEL),    32'(m_level));
        rise_now     = MOVE_REQ && !prev_req;
        ovr_rise_now = OVERRUN && !prev_ovr;
        prev_req     = MOVE_REQ;
        prev_ovr     = OVERRUN;
        if (auto_ack) MOVE_ACK = m_req;
    endtask

    task automatic wait_rise(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (rise_now) begin at = cyc; break; end
        end
        n_assert++;
        assert (at >= 0) else begin
            n_fail++;
            $error("FAIL wait_rise: observed no rise, expected rise within %0d cycles", budget);
        end
    endtask

    initial begin
        int e, r0, r1, r2, r3, rises, ovr_at, found;

        model_reset();
        #2;
        chk("reset_req",     32'(MOVE_REQ), 0);
        chk("reset_paused",  32'(PAUSED),   0);
        chk("reset_overrun", 32'(OVERRUN),  0);
        chk("reset_level",   32'(LEVEL),    0);
        #10 RESET = 1'b1;
        tick(); tick();

        // Cadence at level 0 with one-cycle-late acks.
        MSM_State = 2'b01;
        auto_ack  = 1;
        tick(); e = cyc;
        wait_rise(40, r0); chk("first_rise", 32'(r0 - e), 20);
        wait_rise(40, r1); chk("spacing_l0", 32'(r1 - r0), 20);

        // Level changes take effect only from the next reload.
        SCORE = 8'd8;
        wait_rise(40, r0); chk("old_period_kept", 32'(r0 - r1), 20);
        wait_rise(40, r1); chk("spacing_l2", 32'(r1 - r0), SPEEDUP ? 12 : 20);
        SCORE = 8'd255;
        wait_rise(40, r0); chk("spacing_l2_tail", 32'(r0 - r1), SPEEDUP ? 12 : 20);
        wait_rise(40, r1); chk("spacing_min", 32'(r1 - r0), SPEEDUP ? 8 : 20);
        chk("level_sat", 32'(LEVEL), SPEEDUP ? 15 : 0);

        // Overrun: request left pending past a full period.
        SCORE = 8'd0;
        wait_rise(40, r0);
        wait_rise(40, r1);
        tick();
        auto_ack = 0; MOVE_ACK = 0;
        wait_rise(40, r2); chk("spacing_back_l0", 32'(r2 - r1), 20);
        rises = 0; ovr_at = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rise_now) rises++;
            if (ovr_rise_now && ovr_at < 0) ovr_at = cyc;
        end
        chk("overrun_delay", 32'(ovr_at - r2), 20);
        chk("single_request", 32'(rises), 0);
        chk("req_still_high", 32'(MOVE_REQ), 1);
        MOVE_ACK = 1; tick(); MOVE_ACK = 0;
        chk("req_dropped_on_ack", 32'(MOVE_REQ), 0);
        chk("overrun_sticky", 32'(OVERRUN), 1);

        // Pause with seven edges to go, then resume.
        auto_ack = 1;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (m_active && !m_req && !m_paused && m_left == 7) found = 1;
            else tick();
        end
        chk("found_pause_point", 32'(found), 1);
        PAUSE_KEY = 1; tick(); PAUSE_KEY = 0;
        chk("paused_set", 32'(PAUSED), 1);
        rises = 0;
        for (int i = 0; i < 100; i++) begin tick(); if (rise_now) rises++; end
        chk("no_req_in_pause", 32'(rises), 0);
        PAUSE_KEY = 1; tick(); PAUSE_KEY = 0; e = cyc;
        chk("paused_clear", 32'(PAUSED), 0);
        wait_rise(20, r0); chk("resume_remaining", 32'(r0 - e), 7);

        // Pause key during a pending request takes effect after the ack.
        auto_ack = 0; MOVE_ACK = 0;
        PAUSE_KEY = 1; tick(); PAUSE_KEY = 0;
        chk("no_pause_before_ack", 32'(PAUSED), 0);
        MOVE_ACK = 1; tick(); MOVE_ACK = 0;
        chk("pause_after_ack", 32'(PAUSED), 1);
        chk("req_low_after_ack", 32'(MOVE_REQ), 0);
        PAUSE_KEY = 1; tick(); PAUSE_KEY = 0;

        // Game over while a request is pending, with overrun already flagged.
        wait_rise(30, r0);
        for (int i = 0; i < 22; i++) tick();
        chk("overrun_before_exit", 32'(OVERRUN), 1);
        MSM_State = 2'b11; tick();
        chk("exit_req", 32'(MOVE_REQ), 0);
        chk("exit_overrun_held", 32'(OVERRUN), 1);
        tick(); tick(); tick();
        MSM_State = 2'b01; tick(); e = cyc;
        chk("overrun_cleared", 32'(OVERRUN), 0);
        auto_ack = 1;
        wait_rise(30, r0); chk("restart_full_count", 32'(r0 - e), 20);

        // Asynchronous reset in the middle of a handshake.
        wait_rise(30, r0);
        auto_ack = 0; MOVE_ACK = 0;
        tick(); tick(); tick();
        #3 RESET = 1'b0;
        #1;
        chk("async_req",     32'(MOVE_REQ), 0);
        chk("async_paused",  32'(PAUSED),   0);
        chk("async_overrun", 32'(OVERRUN),  0);
        chk("async_level",   32'(LEVEL),    0);
        model_reset();
        prev_req = 0; prev_ovr = 0;
        @(negedge CLK); RESET = 1'b1;
        tick(); e = cyc;
        auto_ack = 1;
        wait_rise(30, r0); chk("post_reset_count", 32'(r0 - e), 20);

        // Random traffic against the model.
        auto_ack = 0;
        for (int i = 0; i < 1500; i++) begin
            PAUSE_KEY = ($urandom_range(0, 24) == 0);
            MOVE_ACK  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) SCORE = 8'($urandom);
            if ($urandom_range(0, 149) == 0) MSM_State = 2'($urandom);
            if (MSM_State != 2'b01 && $urandom_range(0, 5) == 0) MSM_State = 2'b01;
            tick();
        end
        r3 = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/snake_tick_scheduler.md
Name: snake_tick_scheduler

Overview:
Move-step scheduler for the snake datapath. Generates a rate-controlled MOVE_REQ/MOVE_ACK handshake that tells the snake-control logic when to advance one cell. Step period shortens with score level. Supports pause/resume on the centre key and halts whenever the master state machine leaves PLAY. Sits between the master state machine / debounced key flags and the snake-control block.

Parameters:
BASE_PERIOD, 5000000, clocks per step at level 0
STEP_DEC, 250000, clocks removed from the period per level
MIN_PERIOD, 1000000, floor on the step period
LEVEL_SHIFT, 2, level = SCORE >> LEVEL_SHIFT, saturated at 15
CNT_W, 24, width of the period counter; must hold BASE_PERIOD

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous active-low reset
MSM_State  in  2  master state; 2'b01 = PLAY, every other value = not playing
PAUSE_KEY  in  1  debounced one-cycle pulse (BINC flag)
SCORE  in  8  current game score
MOVE_ACK  in  1  snake control has consumed the step
MOVE_REQ  out  1  step request, held until acknowledged
PAUSED  out  1  high while in PAUSE
LEVEL  out  4  current speed level
OVERRUN  out  1  sticky: a step period expired while a request was still pending

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE, counter=0, MOVE_REQ=0, PAUSED=0, LEVEL=0, OVERRUN=0, pause_pending=0.
- Registered outputs: LEVEL = min(SCORE>>LEVEL_SHIFT, 15), updated every cycle.
- Period computation:
  - Candidate period P = BASE_PERIOD - LEVEL*STEP_DEC.
  - If LEVEL*STEP_DEC > BASE_PERIOD-MIN_PERIOD, P = MIN_PERIOD (no negative wrap).
  - P is sampled only at counter reload; a level change never affects a count in progress.
- States: IDLE, RUN, WAIT_ACK, PAUSE.
- IDLE:
  - MOVE_REQ=0.
  - On MSM_State==01: counter=P-1, OVERRUN=0, go to RUN.
- RUN:
  - Counter decrements every cycle.
  - When counter==0: MOVE_REQ<=1, counter<=P-1, go to WAIT_ACK.
- WAIT_ACK:
  - Counter keeps decrementing. MOVE_REQ stays high.
  - When MOVE_ACK is sampled high: MOVE_REQ<=0 on the next edge, go to RUN (or to PAUSE if pause_pending; clear pause_pending).
  - If counter reaches 0 while still waiting: OVERRUN<=1, counter<=P-1. The tick is dropped; requests are never queued, so MOVE_REQ stays a single request.
  - A simultaneous ACK and expiry counts as an ack plus a reload; OVERRUN is not set.
- MOVE_ACK while MOVE_REQ=0 is ignored.
- Pause handling:
  - PAUSE_KEY in RUN: go to PAUSE, counter frozen, PAUSED=1.
  - PAUSE_KEY coinciding with counter==0 in RUN: the tick wins and pause_pending is set.
  - PAUSE_KEY in WAIT_ACK: sets pause_pending. The request completes first.
  - PAUSE_KEY in PAUSE: go to RUN with the frozen count, PAUSED=0.
- Leaving PLAY: MSM_State!=01 in any non-IDLE state sends the block to IDLE on the next edge. MOVE_REQ=0, PAUSED=0, counter=0, pause_pending=0; OVERRUN is held until the next IDLE->RUN transition.
- Asynchronous reset mid-handshake drops MOVE_REQ immediately; no ACK is required.

Optional Feature:
SNAKE_SPEEDUP_EN
- Defined: period follows LEVEL as described above.
- Undefined: P = BASE_PERIOD constant, LEVEL output tied to 4'd0, SCORE unused; all other behaviour identical.

Test Plan:
All tests use BASE_PERIOD=20, STEP_DEC=4, MIN_PERIOD=8, LEVEL_SHIFT=2, with SNAKE_SPEEDUP_EN defined.
1. Cadence: release reset, MSM_State=01, SCORE=0, MOVE_ACK=MOVE_REQ delayed 1 cycle -> first MOVE_REQ rises 20 cycles after entering RUN, then every 20 cycles; OVERRUN stays 0.
2. Speed levels: SCORE=8 -> LEVEL=2, spacing 12 cycles after the next reload. SCORE=255 -> LEVEL=15, spacing clamps to 8. The current count finishes at the old period.
3. Overrun: hold MOVE_ACK=0 for 30 cycles after MOVE_REQ rises -> OVERRUN=1 at cycle 20, MOVE_REQ stays high, single pulse. ACK -> MOVE_REQ=0 next cycle, OVERRUN stays 1.
4. Pause: PAUSE_KEY when 7 cycles remain -> PAUSED=1, no MOVE_REQ for 100 cycles. Second PAUSE_KEY -> MOVE_REQ rises 7 cycles later. PAUSE_KEY during WAIT_ACK -> PAUSED asserts the cycle after ACK.
5. Game over: MSM_State=11 while MOVE_REQ=1 -> MOVE_REQ=0 and IDLE next edge. Return to 01 -> OVERRUN cleared, full 20-cycle count.
6. Reset: assert RESET=0 between clock edges mid-count -> all outputs 0 immediately. Rebuild without SNAKE_SPEEDUP_EN with SCORE=255 -> LEVEL=0, spacing 20.
